sel_and_pipe: RTL and testbench
===============================

SEL_AND_PIPE -- requirements
Module: sel_and_pipe

Interface
REQ-001 SHALL have parameter W, default 96: data width in bits, legal range >= 2.
REQ-002 SHALL have parameter DEPTH, default 2: number of register stages, legal range >= 1.
REQ-003 SHALL have parameter CW, default 16: width of the transfer counter, legal range >= 1.
REQ-004 SHALL have port clkin_data, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn_data, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream word present.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-008 SHALL have port in_a, input, W bits: operand A.
REQ-009 SHALL have port in_b, input, W bits: operand B.
REQ-010 SHALL have port in_sel, input, W bits: per-bit select; 1 selects A, 0 selects B.
REQ-011 SHALL have port in_mask, input, W bits: AND mask.
REQ-012 SHALL have port in_mode, input, 2 bits: operation, captured with the word.
REQ-013 SHALL have port flush, input, 1 bit: synchronous pipeline clear.
REQ-014 SHALL have port out_valid, output, 1 bit: result present.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-016 SHALL have port out_data, output, W bits: result.
REQ-017 SHALL have port out_count, output, CW bits: completed output transfers.

Function
REQ-018 SHALL form m[i] = in_sel[i] ? in_a[i] : in_b[i] for every bit i at acceptance.
REQ-019 SHALL compute the result per in_mode: 0 gives ~m; 1 gives m & in_mask; 2 gives ~m & in_mask; 3 gives m unchanged.
REQ-020 SHALL register the result into stage 0 on an accept, where an accept is in_valid & in_ready.
REQ-021 SHALL shift results through DEPTH stages; out_data/out_valid SHALL be driven from the last stage only.
REQ-022 SHALL advance a stage when it is valid and the next stage is empty or advancing; the last stage advances on out_ready.
REQ-023 SHALL drive in_ready = ~stage0_valid | stage0_advancing, combinationally, with no dependency on in_valid.
REQ-024 SHALL give a latency of exactly DEPTH cycles from accept to out_valid when out_ready is held high.
REQ-025 SHALL sustain one word per cycle when out_ready is held high.
REQ-026 SHALL keep every stage's data stable while out_ready is low, and SHALL never drop or duplicate a word.
REQ-027 SHALL, when all stages are full and out_ready is high, accept a new word in the same cycle the last stage drains.
REQ-028 SHALL increment out_count on each out_valid & out_ready, wrapping from 2^CW-1 to 0.
REQ-029 SHALL, on flush, clear all stage valids and out_count to 0 on the next edge.
REQ-030 SHALL hold in_ready low during a flush cycle; an in_valid in that cycle SHALL be discarded.
REQ-031 SHALL give flush priority over simultaneous accept, advance and count events.
REQ-032 SHALL keep out_data at its previous value when out_valid is low; the value is don't-care to the consumer.

Reset
REQ-033 SHALL, while rstn_data is low, asynchronously force all stage valids to 0, all stage data to 0, and out_count to 0.
REQ-034 SHALL give in_ready = 1, out_valid = 0, out_data = 0 and out_count = 0 during and after reset.
REQ-035 SHALL discard in-flight words on reset mid-operation; the first word accepted after release SHALL appear after DEPTH cycles.
REQ-036 SHALL release reset with no effect until the first rising edge after rstn_data goes high.

Verification
REQ-037 SHALL pass basic ops: W=96, DEPTH=2, out_ready=1, a=all-1, b=0, sel=0x0...F, mask=0x0...3; modes 0..3 -> out_data = 0xF...F0, 0x0...3, 0x0, 0x0...F, two cycles after each accept.
REQ-038 SHALL pass backpressure: stream 5 words with out_ready=0 for 4 cycles -> in_ready=0 after DEPTH words; when released, all 5 outputs in order, out_count=5.
REQ-039 SHALL pass throughput: 100 back-to-back words with out_ready=1 -> 100 outputs in consecutive cycles; out_count=100.
REQ-040 SHALL pass counter wrap: CW=4, 17 transfers -> out_count=1.
REQ-041 SHALL pass flush: pipeline full, flush plus in_valid asserted together -> next cycle out_valid=0, out_count=0, the new word is absent from the output.
REQ-042 SHALL pass reset mid-stream: rstn_data low for 1 ns between edges with 2 words in flight -> out_valid=0 immediately, no stale word emitted afterwards.

Source files
------------

// File: rtl/sel_and_pipe.sv
// sel_and_pipe: per-bit A/B select, one of four mask/invert operations, then
// a DEPTH-stage elastic register pipeline with valid/ready handshaking on both
// sides, a synchronous flush and a wrapping count of completed output transfers.
module sel_and_pipe #(
    parameter int unsigned W     = 96,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = 16
) (
    input  logic          clkin_data,
    input  logic          rstn_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic [W-1:0]  in_sel,
    input  logic [W-1:0]  in_mask,
    input  logic [1:0]    in_mode,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_count
);

    typedef enum logic [1:0] {
        OP_INV     = 2'd0,
        OP_AND     = 2'd1,
        OP_INV_AND = 2'd2,
        OP_PASS    = 2'd3
    } op_e;

    logic [W-1:0]     sel_m;
    logic [W-1:0]     result;
    logic [DEPTH-1:0] adv;
    logic             accept;
    logic             fire;

    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Per-bit operand select: a set select bit takes A, a clear one takes B.
    always_comb begin
        sel_m = '0;
        for (int unsigned i = 0; i < W; i++) begin
            sel_m[i] = in_sel[i] ? in_a[i] : in_b[i];
        end
    end

    // Operation applied to the selected word before it enters stage 0.
    always_comb begin
        result = sel_m;
        case (op_e'(in_mode))
            OP_INV:     result = ~sel_m;
            OP_AND:     result = sel_m & in_mask;
            OP_INV_AND: result = ~sel_m & in_mask;
            OP_PASS:    result = sel_m;
            default:    result = sel_m;
        endcase
    end

    // Advance chain walked from the output back to stage 0: a stage moves when
    // it holds a word and the stage ahead is empty or itself moving.
    always_comb begin
        logic room;
        logic step;
        adv  = '0;
        room = out_ready;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            step                = valid_q[DEPTH-1-k] & room;
            adv[DEPTH-1-k]      = step;
            room                = ~valid_q[DEPTH-1-k] | step;
        end
    end

    // Handshake terms; flush blocks acceptance for the cycle it is asserted.
    always_comb begin
        in_ready  = ~flush & (~valid_q[0] | adv[0]);
        accept    = in_valid & in_ready;
        out_valid = valid_q[DEPTH-1];
        out_data  = data_q[DEPTH-1];
        out_count = count_q;
        fire      = valid_q[DEPTH-1] & out_ready;
    end

    // Next-state for stage valids, stage data and the transfer counter.
    // Data of a stage only changes when a word enters it, so an emptied last
    // stage keeps presenting its previous word.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            if (fire) begin
                count_d = count_q + CW'(1);
            end
            if (accept) begin
                data_d[0]  = result;
                valid_d[0] = 1'b1;
            end else if (adv[0]) begin
                valid_d[0] = 1'b0;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (adv[i-1]) begin
                    data_d[i]  = data_q[i-1];
                    valid_d[i] = 1'b1;
                end else if (adv[i]) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clkin_data or negedge rstn_data) begin
        if (!rstn_data) begin
            valid_q <= '0;
            data_q  <= '{default: '0};
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_sel_and_pipe.sv
// Self-checking bench for sel_and_pipe: directed phases plus random traffic,
// compared every cycle against a queue-based transaction model.
`timescale 1ns/100ps
module tb_sel_and_pipe;

    localparam int W     = 96;
    localparam int DEPTH = 2;
    localparam int CW    = 16;
    localparam int CWS   = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           in_valid = 1'b0;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic [W-1:0]   in_sel = '0;
    logic [W-1:0]   in_mask = '0;
    logic [1:0]     in_mode = '0;
    logic           flush = 1'b0;
    logic           out_ready = 1'b0;

    logic           in_ready, out_valid;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_count;
    logic           in_ready_s, out_valid_s;
    logic [W-1:0]   out_data_s;
    logic [CWS-1:0] out_count_s;

    always #5 clk = ~clk;

    sel_and_pipe #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
        .clkin_data(clk), .rstn_data(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_mask(in_mask),
        .in_mode(in_mode), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count)
    );

    sel_and_pipe #(.W(W), .DEPTH(DEPTH), .CW(CWS)) dut_s (
        .clkin_data(clk), .rstn_data(rstn),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_mask(in_mask),
        .in_mode(in_mode), .flush(flush),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_count(out_count_s)
    );

    typedef struct {
        logic [W-1:0] d;
        int           acc;
    } ent_t;

    ent_t         q[$];
    int           cyc = 0;
    int           cnt = 0;
    logic [W-1:0] last_out = '0;
    logic         last_acc = 1'b0;
    int           errors = 0;
    int           checks = 0;

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] s, input logic [W-1:0] k,
                                            input logic [1:0] md);
        logic [W-1:0] m;
        m = (a & s) | (b & ~s);
        case (md)
            2'd0:    return ~m;
            2'd1:    return m & k;
            2'd2:    return ~m & k;
            default: return m;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model,
    // then return 1 ns after the rising edge for the caller to drive inputs.
    task automatic step();
        logic ev, ir;
        @(negedge clk);
        ev = (q.size() > 0) && (q[0].acc + DEPTH <= cyc);
        if (ev) last_out = q[0].d;
        ir = !flush && ((q.size() < DEPTH) || (ev && out_ready));
        chk("out_valid", W'(out_valid), W'(ev));
        chk("out_data", out_data, last_out);
        chk("in_ready", W'(in_ready), W'(ir));
        chk("out_count", W'(out_count), W'(cnt % (1 << CW)));
        chk("out_valid_cw4", W'(out_valid_s), W'(ev));
        chk("out_data_cw4", out_data_s, last_out);
        chk("in_ready_cw4", W'(in_ready_s), W'(ir));
        chk("out_count_cw4", W'(out_count_s), W'(cnt % (1 << CWS)));
        last_acc = 1'b0;
        if (flush) begin
            q.delete();
            cnt = 0;
        end else begin
            if (ev && out_ready) begin
                void'(q.pop_front());
                cnt++;
            end
            if (in_valid && ir) begin
                q.push_back('{ref_op(in_a, in_b, in_sel, in_mask, in_mode), cyc});
                last_acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_word();
        in_a    = {$urandom(), $urandom(), $urandom()};
        in_b    = {$urandom(), $urandom(), $urandom()};
        in_sel  = {$urandom(), $urandom(), $urandom()};
        in_mask = {$urandom(), $urandom(), $urandom()};
        in_mode = 2'($urandom_range(0, 3));
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    // Offer fresh random words until n have been accepted (bounded).
    task automatic send_words(input int n, input string tag);
        int got = 0;
        int budget = 200;
        rand_word();
        in_valid = 1'b1;
        while (got < n && budget > 0) begin
            step();
            budget--;
            if (last_acc) begin
                got++;
                rand_word();
            end
        end
        in_valid = 1'b0;
        if (got != n) chk(tag, W'(got), W'(n));
    endtask

    task automatic reset_pulse();
        rstn = 1'b0;
        #1;
        chk("rst_mid_out_valid", W'(out_valid), '0);
        chk("rst_mid_out_data", out_data, '0);
        chk("rst_mid_in_ready", W'(in_ready), W'(1));
        chk("rst_mid_out_count", W'(out_count), '0);
        rstn = 1'b1;
        q.delete();
        cnt = 0;
        last_out = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] basic_exp [4];
        basic_exp[0] = {{(W-4){1'b1}}, 4'h0};
        basic_exp[1] = W'(3);
        basic_exp[2] = '0;
        basic_exp[3] = W'(15);

        // Reset state, while held and after release between edges.
        #2;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_count", W'(out_count), '0);
        #10;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", W'(out_valid), '0);

        // Basic operations, one isolated word per mode.
        out_ready = 1'b1;
        for (int unsigned md = 0; md < 4; md++) begin
            in_a = '1; in_b = '0; in_sel = W'(4'hF); in_mask = W'(2'h3);
            in_mode = 2'(md);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            step();
            chk("basic_mode_data", out_data, basic_exp[md]);
            step();
        end

        // Backpressure: five words, output stalled for the first four cycles.
        do_flush();
        out_ready = 1'b0;
        rand_word();
        in_valid = 1'b1;
        begin
            int got = 0;
            int n = 0;
            while (got < 5 && n < 50) begin
                if (n == 4) out_ready = 1'b1;
                step();
                n++;
                if (last_acc) begin
                    got++;
                    rand_word();
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 2) step();
        chk("bp_count", W'(out_count), W'(5));

        // Throughput: 100 back-to-back words.
        do_flush();
        out_ready = 1'b1;
        send_words(100, "thru_accepted");
        repeat (DEPTH + 2) step();
        chk("thru_count", W'(out_count), W'(100));

        // Counter wrap on the narrow-counter instance.
        do_flush();
        send_words(17, "wrap_accepted");
        repeat (DEPTH + 2) step();
        chk("wrap_count_cw4", W'(out_count_s), W'(1));

        // Flush with a full pipeline and a word offered in the same cycle.
        do_flush();
        out_ready = 1'b0;
        send_words(DEPTH, "flush_fill");
        rand_word();
        in_valid = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", W'(out_valid), '0);
        chk("flush_out_count", W'(out_count), '0);
        out_ready = 1'b1;
        repeat (DEPTH + 3) step();

        // Reset mid-stream with two words in flight.
        out_ready = 1'b1;
        send_words(2, "rst_fill");
        reset_pulse();
        repeat (DEPTH + 3) step();
        send_words(1, "rst_after");
        repeat (DEPTH + 2) step();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            rand_word();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
